// File: rtl/xintf_uart_tx_bridge.sv
// FIFO-buffered 16-bit word to 2x 8N1 UART bytes (low byte first); start bit falls 2 cycles after the write.
// No backpressure: writes to a full FIFO are dropped and flagged in the sticky ovf bit.

// Generic synchronous FIFO with occupancy count; registered pointers, combinational read data.
// Push ignored when full, pop ignored when empty; the caller decides what a refused push means.
module xintf_uart_tx_fifo #(
    parameter int W  = 16,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_dat,
    input  logic          pop,
    output logic [W-1:0]  pop_dat,
    output logic [AW:0]   level,
    output logic          full,
    output logic          empty
);
    localparam logic [AW:0] DEPTH = (AW + 1)'(1 << AW);

    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (level == DEPTH);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= push_dat;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW + 1)'(1);
                2'b01:   level <= level - (AW + 1)'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

// XINTF UART-TX window: queues DSP words, shifts each out as two 8N1 bytes, exports FIFO status.
// No backpressure: overflow drops the word and sets ovf until clr_ovf.
module xintf_uart_tx_bridge #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [15:0]           wr_data,
    input  logic                  clr_ovf,
    output logic                  uart_tx,
    output logic                  busy,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  ovf
);
    localparam int          CW      = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic          byte_sel, byte_sel_n;
    logic [15:0]   hold, hold_n;
    logic          tx_n;
    logic          pop;
    logic [15:0]   pop_dat;
    logic [7:0]    cur_byte;

    xintf_uart_tx_fifo #(
        .W  (16),
        .AW (DEPTH_LOG2)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (wr_en),
        .push_dat (wr_data),
        .pop      (pop),
        .pop_dat  (pop_dat),
        .level    (level),
        .full     (full),
        .empty    (empty)
    );

    // Overflow is judged on the registered full flag; set beats clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf <= 1'b0;
        else if (wr_en && full)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

    assign cur_byte = byte_sel ? hold[15:8] : hold[7:0];
    assign busy     = (state != IDLE);

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        bit_idx_n  = bit_idx;
        byte_sel_n = byte_sel;
        hold_n     = hold;
        tx_n       = 1'b1;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    hold_n     = pop_dat;
                    byte_sel_n = 1'b0;
                    cnt_n      = '0;
                    state_n    = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (cnt == CNT_MAX) begin
                    cnt_n     = '0;
                    bit_idx_n = 3'd0;
                    state_n   = DATA;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            DATA: begin
                tx_n = cur_byte[bit_idx];
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (bit_idx == 3'd7)
                        state_n = STOP;
                    else
                        bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            STOP: begin
                tx_n = 1'b1;
                if (cnt == CNT_MAX) begin
                    cnt_n = '0;
                    if (!byte_sel) begin
                        byte_sel_n = 1'b1;
                        state_n    = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // uart_tx is registered, so the line trails the FSM state by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_idx  <= 3'd0;
            byte_sel <= 1'b0;
            hold     <= 16'h0000;
            uart_tx  <= 1'b1;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_idx_n;
            byte_sel <= byte_sel_n;
            hold     <= hold_n;
            uart_tx  <= tx_n;
        end
    end
endmodule

// File: tb/tb_xintf_uart_tx_bridge.sv
// Directed bench for xintf_uart_tx_bridge with CLKS_PER_BIT=4, DEPTH_LOG2=4.
module tb_xintf_uart_tx_bridge;
    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        clr_ovf;
    logic        uart_tx;
    logic        busy;
    logic        full;
    logic        empty;
    logic [4:0]  level;
    logic        ovf;

    int tests = 0;
    int fails = 0;

    xintf_uart_tx_bridge #(
        .CLKS_PER_BIT (CPB),
        .DEPTH_LOG2   (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .clr_ovf (clr_ovf),
        .uart_tx (uart_tx),
        .busy    (busy),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line level i cycles after the start-bit fall of word w.
    function automatic logic frame_bit(input logic [15:0] w, input int i);
        int k, pos;
        logic [7:0] b;
        k   = i / CPB;
        b   = (k >= 10) ? w[15:8] : w[7:0];
        pos = k % 10;
        if (pos == 0)
            return 1'b0;
        if (pos == 9)
            return 1'b1;
        return b[pos-1];
    endfunction

    task automatic do_write(input logic [15:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] b, output logic ok);
        int n;
        ok = 1'b1;
        b  = 8'h00;
        n  = 0;
        do begin
            @(negedge clk);
            n++;
        end while (uart_tx !== 1'b0 && n < 3000);
        if (uart_tx !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (2) @(negedge clk);
        if (uart_tx !== 1'b0)
            ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            b[i] = uart_tx;
        end
        repeat (CPB) @(negedge clk);
        if (uart_tx !== 1'b1)
            ok = 1'b0;
    endtask

    task automatic recv_word(output logic [15:0] w, output logic ok);
        logic [7:0] lo, hi;
        logic       ok_lo, ok_hi;
        recv_byte(lo, ok_lo);
        recv_byte(hi, ok_hi);
        w  = {hi, lo};
        ok = ok_lo & ok_hi;
    endtask

    task automatic count_low(input int cycles, output int lows);
        lows = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1)
                lows++;
        end
    endtask

    initial begin
        logic        samp [0:242];
        logic [15:0] w;
        logic        ok;
        int          lows;
        int          bad;
        int          first_bad;
        logic        exp_bit;

        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 16'h0000;
        clr_ovf = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tx", uart_tx, 1);
        check("rst_busy", busy, 0);
        check("rst_full", full, 0);
        check("rst_empty", empty, 1);
        check("rst_level", level, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        @(negedge clk);

        // Asynchronous reset mid-frame with a full, overflowed FIFO
        for (int i = 0; i < 18; i++) begin
            wr_en   = 1'b1;
            wr_data = 16'hA000 + 16'(i);
            @(negedge clk);
        end
        wr_en = 1'b0;
        check("pre_rst_ovf", ovf, 1);
        check("pre_rst_full", full, 1);
        repeat (20) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        #3 rst = 1'b1;
        #1;
        check("arst_tx", uart_tx, 1);
        check("arst_level", level, 0);
        check("arst_empty", empty, 1);
        check("arst_full", full, 0);
        check("arst_ovf", ovf, 0);
        check("arst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        count_low(200, lows);
        check("post_rst_line_high", lows, 0);
        check("post_rst_empty", empty, 1);

        // Single word: cycle-exact waveform
        do_write(16'h3A5C);
        check("sw_level_after_wr", level, 1);
        check("sw_busy_before_pop", busy, 0);
        check("sw_tx_before_pop", uart_tx, 1);
        @(negedge clk);
        check("sw_busy_after_pop", busy, 1);
        check("sw_level_after_pop", level, 0);
        check("sw_tx_at_pop", uart_tx, 1);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (uart_tx !== frame_bit(16'h3A5C, i)) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
        end
        check("sw_wave_bad_cycles", bad, 0);
        check("sw_busy_done", busy, 0);
        @(negedge clk);
        check("sw_tx_idle", uart_tx, 1);
        repeat (5) @(negedge clk);

        // Back-to-back words: one idle cycle between words, none between bytes
        wr_en = 1'b1;
        wr_data = 16'h0001;
        @(negedge clk);
        wr_data = 16'h0002;
        @(negedge clk);
        wr_data = 16'h0003;
        @(negedge clk);
        wr_en = 1'b0;
        check("b2b_level_peak", level, 2);
        bad = 0;
        first_bad = -1;
        for (int i = 0; i < 243; i++) begin
            samp[i] = uart_tx;
            if (i < 80)       exp_bit = frame_bit(16'h0001, i);
            else if (i < 81)  exp_bit = 1'b1;
            else if (i < 161) exp_bit = frame_bit(16'h0002, i - 81);
            else if (i < 162) exp_bit = 1'b1;
            else if (i < 242) exp_bit = frame_bit(16'h0003, i - 162);
            else              exp_bit = 1'b1;
            if (samp[i] !== exp_bit) begin
                if (bad == 0) first_bad = i;
                bad++;
            end
            @(negedge clk);
        end
        check("b2b_wave_bad_cycles", bad, 0);
        check("b2b_first_bad_idx", first_bad, -1);
        check("b2b_level_end", level, 0);
        check("b2b_busy_end", busy, 0);
        repeat (5) @(negedge clk);

        // Fill, overflow, clear race; dropped words never transmitted
        fork
            begin
                for (int i = 0; i < 18; i++) begin
                    wr_en   = 1'b1;
                    wr_data = 16'h1000 + 16'(i);
                    @(negedge clk);
                    if (i == 16) begin
                        check("fill_level_16", level, 16);
                        check("fill_ovf_still_0", ovf, 0);
                    end
                end
                check("fill_full", full, 1);
                check("fill_ovf_set", ovf, 1);
                check("fill_level_hold", level, 16);
                wr_data = 16'h1012;
                clr_ovf = 1'b1;
                @(negedge clk);
                check("ovf_race_set_wins", ovf, 1);
                wr_en = 1'b0;
                @(negedge clk);
                clr_ovf = 1'b0;
                check("ovf_cleared", ovf, 0);
            end
            begin
                for (int k = 0; k < 17; k++) begin
                    recv_word(w, ok);
                    check("fill_frame_ok", ok, 1);
                    check("fill_word", w, 16'h1000 + 16'(k));
                end
            end
        join
        count_low(150, lows);
        check("fill_no_extra_word", lows, 0);
        check("fill_empty_end", empty, 1);

        // Pointer wrap: 40 words with the FIFO kept partly full
        fork
            begin
                for (int k = 0; k < 40; k++) begin
                    if (k >= 6)
                        repeat (70) @(negedge clk);
                    do_write(16'(k));
                end
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    recv_word(w, ok);
                    check("wrap_frame_ok", ok, 1);
                    check("wrap_word", w, 16'(k));
                end
            end
        join
        check("wrap_ovf", ovf, 0);
        repeat (5) @(negedge clk);
        check("wrap_empty", empty, 1);
        check("wrap_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
